multi_cycle_control_unit: RTL and testbench

//  Sequencing FSM for the multi-cycle CPU: IF -> ID -> EXE -> MEM -> WB.

---
 rtl/multi_cycle_control_unit_if.sv | 38 +++
 rtl/multi_cycle_control_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle sequencer (master) and the CPU datapath (slave).
// Pure wiring; no latency.
// No flow control; the sequencer drives strobes every cycle.
interface multi_cycle_control_unit_if #(
   parameter int ALUOP_W = 3,
   parameter int STATE_W = 3
);
   logic [5:0]         opCode;
   logic               zero;
   logic               PCWre;
   logic               IRWre;
   logic               InsMemRW;
   logic               RegWre;
   logic               ALUSrcA;
   logic               ALUSrcB;
   logic               ExtSel;
   logic [1:0]         RegDst;
   logic               WrRegDSrc;
   logic               DBDataSrc;
   logic [1:0]         PCSrc;
   logic               mRD;
   logic               mWR;
   logic [ALUOP_W-1:0] ALUOp;
   logic [STATE_W-1:0] State;
   logic               IllegalOp;

   modport master (
      input  opCode, zero,
      output PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel, RegDst,
             WrRegDSrc, DBDataSrc, PCSrc, mRD, mWR, ALUOp, State, IllegalOp
   );

   modport slave (
      output opCode, zero,
      input  PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel, RegDst,
             WrRegDSrc, DBDataSrc, PCSrc, mRD, mWR, ALUOp, State, IllegalOp
   );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU sequencer: IF/ID/EX/MEM/WB FSM with datapath control decode.
// Instructions take 2 (jumps), 3 (beq), 4 (ALU, sw) or 5 (lw) cycles; controls decode in the same cycle.
// No backpressure; HALT (entered on halt or undefined opcode) is left only through Reset.
module multi_cycle_control_unit #(
   parameter int ALUOP_W = 3,
   parameter int STATE_W = 3
) (
   input  logic                       CLK,
   input  logic                       Reset,
   multi_cycle_control_unit_if.master bus
);

   typedef enum logic [2:0] {
      ST_IF  = 3'b000,
      ST_ID  = 3'b001,
      ST_EXM = 3'b010,
      ST_MEM = 3'b011,
      ST_WBL = 3'b100,
      ST_EXB = 3'b101,
      ST_EXA = 3'b110,
      ST_WBA = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SLTI = 6'b100111;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_REG = 2'b10;
   localparam logic [1:0] PC_JMP = 2'b11;

   state_t state;
   logic   halted;
   logic   illegal;

   logic   op_rtype, op_sll, op_imm, op_ori, op_lw, op_sw, op_beq;
   logic   op_j, op_jr, op_jal, op_halt, op_legal;
   logic [ALUOP_W-1:0] alu_dec;

   logic               pc_wre, ir_wre, ins_rd, reg_wre, src_a, src_b, ext_sel;
   logic [1:0]         reg_dst;
   logic               wr_src, db_src;
   logic [1:0]         pc_src;
   logic               m_rd, m_wr;
   logic [ALUOP_W-1:0] alu_op;

   always_comb begin
      op_rtype = 1'b0;
      op_sll   = 1'b0;
      op_imm   = 1'b0;
      op_lw    = 1'b0;
      op_sw    = 1'b0;
      op_beq   = 1'b0;
      op_j     = 1'b0;
      op_jr    = 1'b0;
      op_jal   = 1'b0;
      op_halt  = 1'b0;
      op_legal = 1'b1;
      case (bus.opCode)
         OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: op_rtype = 1'b1;
         OP_SLL:                                op_sll   = 1'b1;
         OP_ADDI, OP_ORI, OP_SLTI:              op_imm   = 1'b1;
         OP_LW:                                 op_lw    = 1'b1;
         OP_SW:                                 op_sw    = 1'b1;
         OP_BEQ:                                op_beq   = 1'b1;
         OP_J:                                  op_j     = 1'b1;
         OP_JR:                                 op_jr    = 1'b1;
         OP_JAL:                                op_jal   = 1'b1;
         OP_HALT:                               op_halt  = 1'b1;
         default:                               op_legal = 1'b0;
      endcase
   end

   assign op_ori = (bus.opCode == OP_ORI);

   always_comb begin
      alu_dec = ALU_ADD;
      case (bus.opCode)
         OP_SUB, OP_BEQ:   alu_dec = ALU_SUB;
         OP_SLL:           alu_dec = ALU_SLL;
         OP_OR, OP_ORI:    alu_dec = ALU_OR;
         OP_AND:           alu_dec = ALU_AND;
         OP_SLT, OP_SLTI:  alu_dec = ALU_SLT;
         default:          alu_dec = ALU_ADD;
      endcase
   end

   // HALT keeps the ID encoding; the halted flag freezes the sequencer.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= ST_IF;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else if (!halted) begin
         case (state)
            ST_IF:  state <= ST_ID;
            ST_ID: begin
               if (op_halt || !op_legal) begin
                  halted <= 1'b1;
                  if (!op_legal) illegal <= 1'b1;
               end else if (op_j || op_jal || op_jr) begin
                  state <= ST_IF;
               end else if (op_beq) begin
                  state <= ST_EXB;
               end else if (op_lw || op_sw) begin
                  state <= ST_EXM;
               end else begin
                  state <= ST_EXA;
               end
            end
            ST_EXA: state <= ST_WBA;
            ST_WBA: state <= ST_IF;
            ST_EXB: state <= ST_IF;
            ST_EXM: state <= ST_MEM;
            ST_MEM: state <= op_lw ? ST_WBL : ST_IF;
            ST_WBL: state <= ST_IF;
            default: state <= ST_IF;
         endcase
      end
   end

   // Reset presents IF-cycle selects with every write strobe held low.
   always_comb begin
      pc_wre  = 1'b0;
      ir_wre  = 1'b0;
      ins_rd  = 1'b0;
      reg_wre = 1'b0;
      src_a   = 1'b0;
      src_b   = 1'b0;
      ext_sel = 1'b1;
      reg_dst = RD_RA;
      wr_src  = 1'b1;
      db_src  = 1'b0;
      pc_src  = PC_SEQ;
      m_rd    = 1'b0;
      m_wr    = 1'b0;
      alu_op  = ALU_ADD;
      if (Reset || state == ST_IF) begin
         ins_rd = 1'b1;
         ir_wre = !Reset;
      end else if (!halted) begin
         src_a   = op_sll;
         src_b   = op_imm | op_lw | op_sw;
         ext_sel = !op_ori;
         if (op_rtype || op_sll)    reg_dst = RD_RD;
         else if (op_imm || op_lw)  reg_dst = RD_RT;
         wr_src  = !op_jal;
         db_src  = op_lw;
         alu_op  = alu_dec;
         case (state)
            ST_ID: begin
               if (op_j || op_jal) begin
                  pc_wre  = 1'b1;
                  pc_src  = PC_JMP;
                  reg_wre = op_jal;
               end else if (op_jr) begin
                  pc_wre = 1'b1;
                  pc_src = PC_REG;
               end
            end
            ST_WBA: begin
               reg_wre = 1'b1;
               pc_wre  = 1'b1;
            end
            ST_EXB: begin
               pc_wre = 1'b1;
               pc_src = bus.zero ? PC_BR : PC_SEQ;
            end
            ST_MEM: begin
               if (op_sw) begin
                  m_wr   = 1'b1;
                  pc_wre = 1'b1;
               end else begin
                  m_rd = 1'b1;
               end
            end
            ST_WBL: begin
               m_rd    = 1'b1;
               reg_wre = 1'b1;
               pc_wre  = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.PCWre     = pc_wre;
   assign bus.IRWre     = ir_wre;
   assign bus.InsMemRW  = ins_rd;
   assign bus.RegWre    = reg_wre;
   assign bus.ALUSrcA   = src_a;
   assign bus.ALUSrcB   = src_b;
   assign bus.ExtSel    = ext_sel;
   assign bus.RegDst    = reg_dst;
   assign bus.WrRegDSrc = wr_src;
   assign bus.DBDataSrc = db_src;
   assign bus.PCSrc     = pc_src;
   assign bus.mRD       = m_rd;
   assign bus.mWR       = m_wr;
   assign bus.ALUOp     = alu_op;
   assign bus.State     = Reset ? '0 : STATE_W'(state);
   assign bus.IllegalOp = illegal & !Reset;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for the multi-cycle sequencer: per-cycle control vectors for each instruction class,
// halt/illegal handling and reset behaviour.
module tb_multi_cycle_control_unit;

   logic CLK = 1'b0;
   logic Reset;

   always #5 CLK = ~CLK;

   multi_cycle_control_unit_if #(.ALUOP_W(3), .STATE_W(3)) bus ();

   multi_cycle_control_unit #(.ALUOP_W(3), .STATE_W(3)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic       pcwre;
      logic       irwre;
      logic       insrd;
      logic       regwre;
      logic       srca;
      logic       srcb;
      logic       ext;
      logic [1:0] regdst;
      logic       wrsrc;
      logic       dbsrc;
      logic [1:0] pcsrc;
      logic       mrd;
      logic       mwr;
      logic [2:0] aluop;
      logic [2:0] state;
      logic       ill;
   } ctl_t;

   int checks = 0;
   int errors = 0;

   function automatic ctl_t sample();
      ctl_t c;
      c.pcwre  = bus.PCWre;
      c.irwre  = bus.IRWre;
      c.insrd  = bus.InsMemRW;
      c.regwre = bus.RegWre;
      c.srca   = bus.ALUSrcA;
      c.srcb   = bus.ALUSrcB;
      c.ext    = bus.ExtSel;
      c.regdst = bus.RegDst;
      c.wrsrc  = bus.WrRegDSrc;
      c.dbsrc  = bus.DBDataSrc;
      c.pcsrc  = bus.PCSrc;
      c.mrd    = bus.mRD;
      c.mwr    = bus.mWR;
      c.aluop  = bus.ALUOp;
      c.state  = bus.State;
      c.ill    = bus.IllegalOp;
      return c;
   endfunction

   // Quiet vector: sign-extend, DB write-back source, nothing strobing.
   function automatic ctl_t base(input logic [2:0] st);
      ctl_t c;
      c       = '0;
      c.ext   = 1'b1;
      c.wrsrc = 1'b1;
      c.state = st;
      return c;
   endfunction

   function automatic ctl_t if_cyc();
      ctl_t c;
      c       = base(3'b000);
      c.irwre = 1'b1;
      c.insrd = 1'b1;
      return c;
   endfunction

   function automatic ctl_t rst_cyc();
      ctl_t c;
      c       = base(3'b000);
      c.insrd = 1'b1;
      return c;
   endfunction

   task automatic test_reset();
      ctl_t got;
      Reset = 1'b1;
      bus.opCode = 6'b000000;
      bus.zero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1; got = sample(); checks++;
         if (got !== rst_cyc()) begin
            errors++;
            $display("FAIL reset cyc%0d: got %h, expected %h", i, got, rst_cyc());
         end
         @(negedge CLK);
      end
      Reset = 1'b0;
   endtask

   task automatic test_add();
      ctl_t e [4];
      ctl_t got;
      e[0] = if_cyc();
      e[1] = base(3'b001); e[1].regdst = 2'b10;
      e[2] = base(3'b110); e[2].regdst = 2'b10;
      e[3] = base(3'b111); e[3].regdst = 2'b10; e[3].regwre = 1'b1; e[3].pcwre = 1'b1;
      bus.opCode = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         #1; got = sample(); checks++;
         if (got !== e[i]) begin
            errors++;
            $display("FAIL add cyc%0d: got %h, expected %h", i, got, e[i]);
         end
         @(negedge CLK);
      end
      #1; checks++;
      if (bus.State !== 3'b000) begin
         errors++;
         $display("FAIL add_return: State %b, expected 000", bus.State);
      end
   endtask

   task automatic test_lw();
      ctl_t e [5];
      ctl_t got;
      e[0] = if_cyc();
      e[1] = base(3'b001);
      e[1].srcb = 1'b1; e[1].regdst = 2'b01; e[1].dbsrc = 1'b1;
      e[2] = e[1]; e[2].state = 3'b010;
      e[3] = e[1]; e[3].state = 3'b011; e[3].mrd = 1'b1;
      e[4] = e[1]; e[4].state = 3'b100; e[4].mrd = 1'b1; e[4].regwre = 1'b1; e[4].pcwre = 1'b1;
      bus.opCode = 6'b110001;
      for (int i = 0; i < 5; i++) begin
         #1; got = sample(); checks++;
         if (got !== e[i]) begin
            errors++;
            $display("FAIL lw cyc%0d: got %h, expected %h", i, got, e[i]);
         end
         @(negedge CLK);
      end
      #1; checks++;
      if (bus.State !== 3'b000) begin
         errors++;
         $display("FAIL lw_return: State %b, expected 000", bus.State);
      end
   endtask

   task automatic test_sw();
      ctl_t e [4];
      ctl_t got;
      e[0] = if_cyc();
      e[1] = base(3'b001); e[1].srcb = 1'b1;
      e[2] = e[1]; e[2].state = 3'b010;
      e[3] = e[1]; e[3].state = 3'b011; e[3].mwr = 1'b1; e[3].pcwre = 1'b1;
      bus.opCode = 6'b110000;
      for (int i = 0; i < 4; i++) begin
         #1; got = sample(); checks++;
         if (got !== e[i]) begin
            errors++;
            $display("FAIL sw cyc%0d: got %h, expected %h", i, got, e[i]);
         end
         @(negedge CLK);
      end
      #1; checks++;
      if (bus.State !== 3'b000) begin
         errors++;
         $display("FAIL sw_return: State %b, expected 000", bus.State);
      end
   endtask

   task automatic test_beq();
      ctl_t e [3];
      ctl_t got;
      logic z;
      for (int k = 0; k < 2; k++) begin
         z = (k == 0);
         e[0] = if_cyc();
         e[1] = base(3'b001); e[1].aluop = 3'b001;
         e[2] = base(3'b101); e[2].aluop = 3'b001; e[2].pcwre = 1'b1;
         e[2].pcsrc = z ? 2'b01 : 2'b00;
         bus.opCode = 6'b110100;
         bus.zero = z;
         for (int i = 0; i < 3; i++) begin
            #1; got = sample(); checks++;
            if (got !== e[i]) begin
               errors++;
               $display("FAIL beq(zero=%0d) cyc%0d: got %h, expected %h", z, i, got, e[i]);
            end
            @(negedge CLK);
         end
         #1; checks++;
         if (bus.State !== 3'b000) begin
            errors++;
            $display("FAIL beq_return(zero=%0d): State %b, expected 000", z, bus.State);
         end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jumps();
      logic [5:0] ops [3];
      ctl_t e [2];
      ctl_t got;
      ops = '{6'b111000, 6'b111010, 6'b111001};
      for (int k = 0; k < 3; k++) begin
         e[0] = if_cyc();
         e[1] = base(3'b001); e[1].pcwre = 1'b1;
         case (k)
            0: e[1].pcsrc = 2'b11;
            1: begin e[1].pcsrc = 2'b11; e[1].regwre = 1'b1; e[1].wrsrc = 1'b0; end
            default: e[1].pcsrc = 2'b10;
         endcase
         bus.opCode = ops[k];
         for (int i = 0; i < 2; i++) begin
            #1; got = sample(); checks++;
            if (got !== e[i]) begin
               errors++;
               $display("FAIL jump(op=%b) cyc%0d: got %h, expected %h", ops[k], i, got, e[i]);
            end
            @(negedge CLK);
         end
         #1; checks++;
         if (bus.State !== 3'b000) begin
            errors++;
            $display("FAIL jump_return(op=%b): State %b, expected 000", ops[k], bus.State);
         end
      end
   endtask

   task automatic test_alu_ops();
      logic [5:0] ops  [8];
      logic [2:0] aop  [8];
      logic       sa   [8];
      logic       sb   [8];
      logic       ex   [8];
      logic [1:0] rd   [8];
      ctl_t e [4];
      ctl_t got;
      //        sub        addi       or         and        ori        sll        slt        slti
      ops = '{6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b011000, 6'b100110, 6'b100111};
      aop = '{3'b001,    3'b000,    3'b011,    3'b100,    3'b011,    3'b010,    3'b101,    3'b101};
      sa  = '{1'b0,      1'b0,      1'b0,      1'b0,      1'b0,      1'b1,      1'b0,      1'b0};
      sb  = '{1'b0,      1'b1,      1'b0,      1'b0,      1'b1,      1'b0,      1'b0,      1'b1};
      ex  = '{1'b1,      1'b1,      1'b1,      1'b1,      1'b0,      1'b1,      1'b1,      1'b1};
      rd  = '{2'b10,     2'b01,     2'b10,     2'b10,     2'b01,     2'b10,     2'b10,     2'b01};
      for (int k = 0; k < 8; k++) begin
         e[0] = if_cyc();
         e[1] = base(3'b001);
         e[1].aluop = aop[k]; e[1].srca = sa[k]; e[1].srcb = sb[k];
         e[1].ext = ex[k]; e[1].regdst = rd[k];
         e[2] = e[1]; e[2].state = 3'b110;
         e[3] = e[1]; e[3].state = 3'b111; e[3].regwre = 1'b1; e[3].pcwre = 1'b1;
         bus.opCode = ops[k];
         for (int i = 0; i < 4; i++) begin
            #1; got = sample(); checks++;
            if (got !== e[i]) begin
               errors++;
               $display("FAIL alu(op=%b) cyc%0d: got %h, expected %h", ops[k], i, got, e[i]);
            end
            @(negedge CLK);
         end
      end
   endtask

   task automatic halt_and_recover(input logic [5:0] op, input logic ill);
      ctl_t e_halt;
      ctl_t got;
      e_halt = base(3'b001);
      e_halt.ill = ill;
      bus.opCode = op;
      #1; got = sample(); checks++;
      if (got !== if_cyc()) begin
         errors++;
         $display("FAIL halt(op=%b) IF: got %h, expected %h", op, got, if_cyc());
      end
      @(negedge CLK);
      #1; got = sample(); checks++;
      if (got !== base(3'b001)) begin
         errors++;
         $display("FAIL halt(op=%b) ID: got %h, expected %h", op, got, base(3'b001));
      end
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) bus.opCode = 6'b000000;
         #1; got = sample(); checks++;
         if (got !== e_halt) begin
            errors++;
            $display("FAIL halt(op=%b) held cyc%0d: got %h, expected %h", op, i, got, e_halt);
         end
         @(negedge CLK);
      end
      Reset = 1'b1;
      #1; got = sample(); checks++;
      if (got !== rst_cyc()) begin
         errors++;
         $display("FAIL halt(op=%b) reset: got %h, expected %h", op, got, rst_cyc());
      end
      @(negedge CLK);
      Reset = 1'b0;
      #1; got = sample(); checks++;
      if (got !== if_cyc()) begin
         errors++;
         $display("FAIL halt(op=%b) after reset: got %h, expected %h", op, got, if_cyc());
      end
   endtask

   task automatic test_halt();
      halt_and_recover(6'b111111, 1'b0);
   endtask

   task automatic test_illegal();
      halt_and_recover(6'b101010, 1'b1);
   endtask

   task automatic test_reset_mid_sw();
      ctl_t got;
      bus.opCode = 6'b110000;
      for (int i = 0; i < 3; i++) @(negedge CLK);
      #1; checks++;
      if (bus.State !== 3'b011) begin
         errors++;
         $display("FAIL sw_abort reach MEM: State %b, expected 011", bus.State);
      end
      Reset = 1'b1;
      #1; got = sample(); checks++;
      if (got !== rst_cyc()) begin
         errors++;
         $display("FAIL sw_abort reset cycle: got %h, expected %h", got, rst_cyc());
      end
      @(negedge CLK);
      Reset = 1'b0;
      #1; got = sample(); checks++;
      if (got !== if_cyc()) begin
         errors++;
         $display("FAIL sw_abort next cycle: got %h, expected %h", got, if_cyc());
      end
   endtask

   initial begin
      Reset = 1'b1;
      bus.opCode = 6'b000000;
      bus.zero = 1'b0;
      @(negedge CLK);
      test_reset();
      test_add();
      test_lw();
      test_sw();
      test_beq();
      test_jumps();
      test_alu_ops();
      test_halt();
      test_illegal();
      test_reset_mid_sw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
